instr_fetch_unit: RTL and testbench

- Upstream stage of the control unit. Fetches 16-bit instructions from byte-wide RAM, low byte at PC and high byte at PC+1.
- Assembles each instruction, tags it with its start address (PC_past) and buffers up to DEPTH instructions for the decoder.
- Hand-off to the decoder is a valid/ready handshake. Yields the memory port whenever the execute stage (LD/ST/PUL/PSH) claims it. Accepts branch redirects (BRA/BNE).

---
 rtl/instr_fetch_unit.sv | 182 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage of the control unit. Reads 16-bit instructions as two bytes
//   (low byte at PC, high byte at PC+1) from a byte-wide asynchronous RAM,
//   tags each one with its start address and queues it in a small circular
//   buffer. The decoder takes instructions over a valid/ready handshake.
//   The RAM port is yielded whenever the execute stage claims it, and a taken
//   branch flushes the buffer and restarts fetching at the branch target.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   mem_addr            RAM byte address (always the PC register)
//   mem_cs              RAM chip select, active low
//   mem_wr              RAM write enable, tied low (read only)
//   mem_rdata           RAM read data, valid in the same cycle as the address
//   mem_busy            execute stage owns the RAM this cycle
//   instr, instr_pc     head-of-buffer instruction and its start address
//   instr_valid         buffer is non-empty
//   instr_ready         decoder consumes the head this cycle
//   redirect            branch taken: flush and restart fetch
//   redirect_addr       branch target
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                  ADDR_W   = 8,
  parameter int                  DEPTH    = 2,
  parameter logic [ADDR_W-1:0]   RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_cs,
  output logic              mem_wr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_busy,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    ST_LO = 1'b0,
    ST_HI = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] start_pc_q, start_pc_d;
  logic [7:0]        lo_byte_q, lo_byte_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [15:0]       buf_instr_q [DEPTH];
  logic [15:0]       buf_instr_d [DEPTH];
  logic [ADDR_W-1:0] buf_pc_q    [DEPTH];
  logic [ADDR_W-1:0] buf_pc_d    [DEPTH];

  logic access_s;
  logic push_s;
  logic pop_s;
  logic valid_s;

  assign valid_s = (count_q != {CNT_W{1'b0}});
  assign pop_s   = valid_s & instr_ready;

  // Fetch FSM next state, RAM access decision and buffer bookkeeping.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    start_pc_d  = start_pc_q;
    lo_byte_d   = lo_byte_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    access_s    = 1'b0;
    push_s      = 1'b0;

    if (!rst_n) begin
      // Outputs must show the idle RAM port while reset is held.
      access_s = 1'b0;
    end else if (redirect) begin
      // Flush wins over everything, including a same-cycle pop.
      pc_d    = redirect_addr;
      state_d = ST_LO;
      head_d  = {PTR_W{1'b0}};
      tail_d  = {PTR_W{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_LO: begin
          // Only start an instruction if a buffer slot is (or is becoming) free,
          // so the HI write can never overflow.
          if (!mem_busy && ((count_q < CNT_W'(DEPTH)) || pop_s)) begin
            access_s   = 1'b1;
            lo_byte_d  = mem_rdata;
            start_pc_d = pc_q;
            pc_d       = pc_q + ADDR_W'(1);
            state_d    = ST_HI;
          end else begin
            access_s = 1'b0;
          end
        end
        ST_HI: begin
          if (!mem_busy) begin
            access_s              = 1'b1;
            push_s                = 1'b1;
            buf_instr_d[tail_q]   = {mem_rdata, lo_byte_q};
            buf_pc_d[tail_q]      = start_pc_q;
            pc_d                  = pc_q + ADDR_W'(1);
            state_d               = ST_LO;
          end else begin
            access_s = 1'b0;
          end
        end
        default: begin
          state_d = ST_LO;
        end
      endcase

      if (push_s) begin
        tail_d = tail_q + PTR_W'(1);
      end else begin
        tail_d = tail_q;
      end

      if (pop_s) begin
        head_d = head_q + PTR_W'(1);
      end else begin
        head_d = head_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State, PC, partial-instruction and buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LO;
      pc_q       <= RESET_PC;
      start_pc_q <= {ADDR_W{1'b0}};
      lo_byte_q  <= 8'h00;
      head_q     <= {PTR_W{1'b0}};
      tail_q     <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        buf_instr_q[i] <= 16'h0000;
        buf_pc_q[i]    <= {ADDR_W{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      start_pc_q  <= start_pc_d;
      lo_byte_q   <= lo_byte_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  assign mem_addr    = pc_q;
  assign mem_cs      = ~access_s;
  assign mem_wr      = 1'b0;
  assign instr_valid = valid_s;
  assign instr       = valid_s ? buf_instr_q[head_q] : 16'h0000;
  assign instr_pc    = valid_s ? buf_pc_q[head_q]    : {ADDR_W{1'b0}};

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
// Testbench for instr_fetch_unit: directed scenarios, scoreboard of expected
// instructions popped by a monitor on each decoder handshake.
module tb_instr_fetch_unit;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  pc;
  } exp_t;

  logic       clk = 1'b0;
  logic [7:0] ram [256];

  // DUT 0: RESET_PC = 0
  logic       rst_n, mem_cs, mem_wr, mem_busy, instr_valid, instr_ready, redirect;
  logic [7:0] mem_addr, mem_rdata, instr_pc, redirect_addr;
  logic [15:0] instr;

  // DUT 1: RESET_PC = 0xFF (wrap-around)
  logic       rst_n1, mem_cs1, mem_wr1, instr_valid1;
  logic       mem_busy1 = 1'b0, instr_ready1 = 1'b1, redirect1 = 1'b0;
  logic [7:0] mem_addr1, mem_rdata1, instr_pc1;
  logic [7:0] redirect_addr1 = 8'h00;
  logic [15:0] instr1;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign mem_rdata  = ram[mem_addr];
  assign mem_rdata1 = ram[mem_addr1];

  instr_fetch_unit #(.ADDR_W(8), .DEPTH(2), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_cs(mem_cs),
    .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_addr(redirect_addr)
  );

  instr_fetch_unit #(.ADDR_W(8), .DEPTH(2), .RESET_PC(8'hFF)) dut_wrap (
    .clk(clk), .rst_n(rst_n1), .mem_addr(mem_addr1), .mem_cs(mem_cs1),
    .mem_wr(mem_wr1), .mem_rdata(mem_rdata1), .mem_busy(mem_busy1),
    .instr(instr1), .instr_pc(instr_pc1), .instr_valid(instr_valid1),
    .instr_ready(instr_ready1), .redirect(redirect1), .redirect_addr(redirect_addr1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two cycles; caller releases it at posedge+1 (cycle 0).
  task automatic start();
    rst_n = 1'b0;
    mem_busy = 1'b0;
    redirect = 1'b0;
    redirect_addr = 8'h00;
    repeat (2) tick();
  endtask

  task automatic expect_instr(input logic [15:0] i, input logic [7:0] p);
    exp_t e;
    e.instr = i;
    e.pc    = p;
    sb.push_back(e);
  endtask

  // Monitor: compare every handshake against the scoreboard; check RAM ownership.
  always @(negedge clk) begin
    if (rst_n && mem_busy) check("cs_while_busy", {31'd0, mem_cs}, 32'd1);
    if (rst_n && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pop: got instr %0h pc %0h expected none", instr, instr_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_instr", {16'd0, instr}, {16'd0, e.instr});
        check("sb_pc", {24'd0, instr_pc}, {24'd0, e.pc});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    rst_n = 1'b0; rst_n1 = 1'b0;
    mem_busy = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_addr = 8'h00;
    repeat (2) tick();

    // Reset state
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", {16'd0, instr}, 32'd0);
    check("rst_pc", {24'd0, instr_pc}, 32'd0);
    check("rst_cs", {31'd0, mem_cs}, 32'd1);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_wr", {31'd0, mem_wr}, 32'd0);

    // Basic fetch
    ram[0] = 8'h34; ram[1] = 8'h12; ram[2] = 8'h78; ram[3] = 8'h56;
    start();
    instr_ready = 1'b1;
    expect_instr(16'h1234, 8'h00);
    expect_instr(16'h5678, 8'h02);
    rst_n = 1'b1; #1;
    check("b_addr0", {24'd0, mem_addr}, 32'h0); check("b_cs0", {31'd0, mem_cs}, 32'd0);
    tick();
    check("b_addr1", {24'd0, mem_addr}, 32'h1); check("b_cs1", {31'd0, mem_cs}, 32'd0);
    check("b_valid1", {31'd0, instr_valid}, 32'd0);
    tick();
    check("b_addr2", {24'd0, mem_addr}, 32'h2); check("b_cs2", {31'd0, mem_cs}, 32'd0);
    check("b_valid2", {31'd0, instr_valid}, 32'd1);
    tick();
    check("b_addr3", {24'd0, mem_addr}, 32'h3); check("b_cs3", {31'd0, mem_cs}, 32'd0);
    check("b_valid3", {31'd0, instr_valid}, 32'd0);
    tick();
    check("b_valid4", {31'd0, instr_valid}, 32'd1);
    tick();
    check("b_sb_empty", sb.size(), 32'd0);

    // Back-pressure
    start();
    instr_ready = 1'b0;
    expect_instr(16'h1234, 8'h00);
    expect_instr(16'h5678, 8'h02);
    expect_instr(16'h0504, 8'h04);
    rst_n = 1'b1; #1;
    repeat (4) tick();
    check("bp_cs4", {31'd0, mem_cs}, 32'd1); check("bp_addr4", {24'd0, mem_addr}, 32'h4);
    check("bp_instr4", {16'd0, instr}, 32'h1234);
    tick();
    check("bp_cs5", {31'd0, mem_cs}, 32'd1); check("bp_addr5", {24'd0, mem_addr}, 32'h4);
    instr_ready = 1'b1; #1;
    check("bp_resume_cs", {31'd0, mem_cs}, 32'd0);
    check("bp_resume_addr", {24'd0, mem_addr}, 32'h4);
    repeat (3) tick();
    check("bp_sb_empty", sb.size(), 32'd0);

    // Memory stall during the first HI cycle
    start();
    instr_ready = 1'b1;
    expect_instr(16'h1234, 8'h00);
    expect_instr(16'h5678, 8'h02);
    rst_n = 1'b1; #1;
    check("st_cs0", {31'd0, mem_cs}, 32'd0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      mem_busy = 1'b1; #1;
      check("st_cs_busy", {31'd0, mem_cs}, 32'd1);
      check("st_addr_hold", {24'd0, mem_addr}, 32'h1);
      check("st_valid_busy", {31'd0, instr_valid}, 32'd0);
    end
    tick();
    mem_busy = 1'b0; #1;
    check("st_cs4", {31'd0, mem_cs}, 32'd0); check("st_addr4", {24'd0, mem_addr}, 32'h1);
    check("st_valid4", {31'd0, instr_valid}, 32'd0);
    tick();
    check("st_valid5", {31'd0, instr_valid}, 32'd1);
    check("st_instr5", {16'd0, instr}, 32'h1234);
    repeat (3) tick();
    check("st_sb_empty", sb.size(), 32'd0);

    // Redirect in the HI cycle with one instruction buffered
    start();
    instr_ready = 1'b0;
    expect_instr(16'h4140, 8'h40);
    rst_n = 1'b1; #1;
    repeat (2) tick();
    check("rd_valid2", {31'd0, instr_valid}, 32'd1);
    tick();
    redirect = 1'b1; redirect_addr = 8'h40; #1;
    check("rd_cs3", {31'd0, mem_cs}, 32'd1);
    tick();
    redirect = 1'b0; instr_ready = 1'b1; #1;
    check("rd_flushed", {31'd0, instr_valid}, 32'd0);
    check("rd_addr4", {24'd0, mem_addr}, 32'h40); check("rd_cs4", {31'd0, mem_cs}, 32'd0);
    tick();
    check("rd_addr5", {24'd0, mem_addr}, 32'h41);
    tick();
    check("rd_pc6", {24'd0, instr_pc}, 32'h40);
    tick();
    check("rd_sb_empty", sb.size(), 32'd0);

    // Asynchronous reset while in HI with one entry buffered
    start();
    instr_ready = 1'b0;
    rst_n = 1'b1; #1;
    repeat (3) tick();
    check("ar_valid3", {31'd0, instr_valid}, 32'd1);
    check("ar_cs3", {31'd0, mem_cs}, 32'd0); check("ar_addr3", {24'd0, mem_addr}, 32'h3);
    #2 rst_n = 1'b0; #1;
    check("ar_valid_now", {31'd0, instr_valid}, 32'd0);
    check("ar_cs_now", {31'd0, mem_cs}, 32'd1);
    check("ar_addr_now", {24'd0, mem_addr}, 32'h0);
    repeat (2) tick();
    instr_ready = 1'b1;
    expect_instr(16'h1234, 8'h00);
    rst_n = 1'b1; #1;
    check("ar_restart_addr", {24'd0, mem_addr}, 32'h0);
    check("ar_restart_cs", {31'd0, mem_cs}, 32'd0);
    repeat (2) tick();
    check("ar_valid2", {31'd0, instr_valid}, 32'd1);
    tick();
    check("ar_sb_empty", sb.size(), 32'd0);
    rst_n = 1'b0;

    // PC wrap-around on the RESET_PC = 0xFF instance
    ram[8'hFF] = 8'hCD; ram[8'h00] = 8'hAB;
    tick();
    rst_n1 = 1'b1; #1;
    check("w_addr0", {24'd0, mem_addr1}, 32'hFF); check("w_cs0", {31'd0, mem_cs1}, 32'd0);
    check("w_wr", {31'd0, mem_wr1}, 32'd0);
    tick();
    check("w_addr1", {24'd0, mem_addr1}, 32'h00);
    tick();
    check("w_valid", {31'd0, instr_valid1}, 32'd1);
    check("w_instr", {16'd0, instr1}, 32'hABCD);
    check("w_pc", {24'd0, instr_pc1}, 32'hFF);
    check("w_next_addr", {24'd0, mem_addr1}, 32'h01);
    check("w_next_cs", {31'd0, mem_cs1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
